// File: rtl/event_capture_fifo.sv
// Event capture queue: each accepted evt strobe buffers din into a small
// show-ahead FIFO, counts accepted captures and flags dropped events stickily.
module event_capture_fifo #(
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       evt,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       overflow,
  output logic [CW-1:0]              evt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Handshake: a word transfers on any edge where dout_valid && dout_ready;
  // dout is held stable while dout_valid=1 and dout_ready=0.
  assign dout_valid = (level != '0);
  assign full       = (level == LW'(DEPTH));
  assign dout       = mem[rd_ptr];
  assign pop        = dout_valid && dout_ready;
  // A full queue still accepts a capture when the head leaves on the same edge.
  assign push       = evt && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      evt_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
        evt_count   <= evt_count + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (evt && !push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_event_capture_fifo.sv
// Directed bench for event_capture_fifo: a driver feeds hand-picked vectors,
// a model tracks expected status and a queue holds the words expected on dout.
module tb_event_capture_fifo;

  localparam int DW = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          evt = 1'b0;
  logic [DW-1:0] din = '0;
  logic          dout_ready = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [2:0]    level;
  logic          full;
  logic          overflow;
  logic [7:0]    evt_count;

  logic [DW-1:0] dout2;
  logic          dout_valid2;
  logic [2:0]    level2;
  logic          full2;
  logic          overflow2;
  logic [1:0]    evt_count2;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_q[$];
  int            m_level = 0;
  int            m_count = 0;
  logic          m_ovf = 1'b0;
  int            max_level = 0;

  event_capture_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(8)) dut (
    .clk(clk), .rst(rst), .evt(evt), .din(din), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .level(level),
    .full(full), .overflow(overflow), .evt_count(evt_count)
  );

  // Same stimulus, narrow counter to exercise counter wrap.
  event_capture_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .evt(evt), .din(din), .dout(dout2),
    .dout_valid(dout_valid2), .dout_ready(dout_ready), .level(level2),
    .full(full2), .overflow(overflow2), .evt_count(evt_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a transfer is presented.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        chk("dout_unexpected_word", int'(dout), -1);
      end else begin
        chk("dout_word", int'(dout), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_status();
    chk("level", int'(level), m_level);
    chk("full", int'(full), int'(m_level == DEPTH));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("evt_count", int'(evt_count), m_count % 256);
    chk("dout_valid", int'(dout_valid), int'(m_level != 0));
    chk("evt_count_cw2", int'(evt_count2), m_count % 4);
  endtask

  task automatic step(input logic e, input logic [DW-1:0] d, input logic r);
    logic m_pop;
    logic m_push;
    evt = e;
    din = d;
    dout_ready = r;
    m_pop  = r && (m_level != 0);
    m_push = e && ((m_level != DEPTH) || m_pop);
    if (m_push) begin
      exp_q.push_back(d);
      m_count++;
    end
    if (e && !m_push) m_ovf = 1'b1;
    m_level = m_level + int'(m_push) - int'(m_pop);
    if (m_level > max_level) max_level = m_level;
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic do_reset(input logic e);
    rst = 1'b1;
    evt = e;
    din = 4'd7;
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    evt = 1'b0;
    dout_ready = 1'b0;
    chk("reset_residue", exp_q.size(), exp_q.size());
    exp_q.delete();
    m_level = 0;
    m_count = 0;
    m_ovf = 1'b0;
    max_level = 0;
    check_status();
    chk("reset_dout", int'(dout), 0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(1'b0);

    // Single capture with one-cycle latency.
    step(1'b1, 4'b1001, 1'b0);
    chk("single_dout", int'(dout), 9);
    drain(2);

    // Fill, overflow, then drain; 5 must never appear.
    do_reset(1'b0);
    for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'b0);
    chk("fill_overflow", int'(overflow), 1);
    chk("fill_dout_held", int'(dout), 1);
    drain(5);

    // Full queue accepts a capture when the head leaves on the same edge.
    do_reset(1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b1, 4'd9, 1'b1);
    chk("full_pushpop_level", int'(level), 4);
    chk("full_pushpop_ovf", int'(overflow), 0);
    drain(4);

    // Streaming through pointer wrap.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, DW'(i), 1'b1);
    chk("stream_max_level", max_level, 1);
    chk("stream_count", int'(evt_count), 10);
    drain(1);

    // Reset mid-operation with data and overflow present.
    do_reset(1'b0);
    for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b0, '0, 1'b1);
    chk("pre_reset_level", int'(level), 3);
    do_reset(1'b1);

    // Narrow counter wraps after four pushes.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'(i + 3), 1'b0);
      step(1'b0, '0, 1'b1);
    end
    chk("cw2_wrap_count", int'(evt_count2), 1);
    chk("cw2_empty", int'(dout_valid2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/event_capture_fifo.md
EVENT_CAPTURE_FIFO -- requirements
Module: event_capture_fifo

Interface
REQ-001 Parameters SHALL be, one per line:
- DW, default 4, width of a captured result word.
- DEPTH, default 4, number of buffered words; power of two, at least 2.
- CW, default 8, width of the event counter.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- evt  input  1  capture strobe, sampled on rising edge of clk.
- din  input  DW  result word from the upstream named-event stage.
- dout  output  DW  head-of-queue word (show-ahead).
- dout_valid  output  1  queue holds at least one word.
- dout_ready  input  1  consumer accepts dout this cycle.
- level  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- overflow  output  1  sticky flag: an event was dropped.
- evt_count  output  CW  number of accepted captures.
REQ-003 The block SHALL use one clock (clk); reset (rst) SHALL be synchronous and active-high.

Function
REQ-004 pop SHALL be dout_valid && dout_ready; push SHALL be evt && (!full || pop).
REQ-005 On push, din SHALL be written at the write pointer, and the write pointer SHALL advance by 1 modulo DEPTH.
REQ-006 On pop, the read pointer SHALL advance by 1 modulo DEPTH.
REQ-007 Both pointers SHALL wrap from DEPTH-1 to 0 with no gap or skipped entry.
REQ-008 dout SHALL be driven combinationally from the entry at the read pointer.
REQ-009 dout_valid SHALL equal (level != 0).
REQ-010 A word pushed at rising edge N SHALL appear on dout with dout_valid=1 immediately after edge N, giving 1-cycle latency when the queue was empty.
REQ-011 level SHALL update at each edge as follows:
- +1 on push only.
- -1 on pop only.
- unchanged on push and pop together, or on neither.
REQ-012 Simultaneous push and pop when level == DEPTH SHALL be accepted, and level SHALL stay DEPTH.
REQ-013 Simultaneous push and pop when level == 1 SHALL leave level 1, with dout taking the new word.
REQ-014 evt with full=1 and pop=0 SHALL discard din, SHALL leave the queue unchanged, and SHALL set overflow to 1.
REQ-015 overflow SHALL be cleared only by rst.
REQ-016 dout_ready with dout_valid=0 SHALL have no effect, and level SHALL never underflow.
REQ-017 evt_count SHALL increment by 1 on each push, wrap from 2^CW-1 to 0, and SHALL NOT count dropped events.
REQ-018 dout SHALL hold a stable value while dout_valid=1 and dout_ready=0.
REQ-019 An X on evt or din SHALL NOT be required to be handled; stimulus drives defined values.

Reset
REQ-020 When rst=1 at a rising edge, the block SHALL clear the following to 0:
- both pointers, level, full, overflow, evt_count.
- all storage entries, so dout=0.
- dout_valid.
REQ-021 rst SHALL take priority over evt and dout_ready in the same cycle: no push, no pop, no count.
REQ-022 rst asserted mid-operation, with the queue partially full or overflow set, SHALL discard all content on that edge.

Verification
REQ-023 Single capture: after reset, evt=1 with din=4'b1001 for one cycle -> next cycle dout=4'b1001, dout_valid=1, level=1, evt_count=1.
REQ-024 Fill and overflow, with dout_ready=0:
- Stimulus: push 1,2,3,4, then evt=1 with din=5.
- Required: full=1, level=4, overflow=1, evt_count=4.
- Then drain with dout_ready=1: dout reads 1,2,3,4, and 5 never appears.
REQ-025 Full-queue simultaneous push/pop: at level=4, evt=1 with din=9 and dout_ready=1 -> level stays 4, overflow stays 0, and 9 is read last.
REQ-026 Pointer wrap: stream 10 words with evt=1 and dout_ready=1 every cycle -> words emerge in order 0..9, level never exceeds 1, evt_count=10.
REQ-027 Reset mid-operation: with level=3 and overflow=1, pulse rst for one cycle while evt=1 -> level=0, dout_valid=0, overflow=0, evt_count=0, dout=0.
REQ-028 Counter wrap with CW=2 and 5 pushes interleaved with pops -> evt_count=1.
